// File: rtl/io_nwell_bias_seq.sv
// io_nwell_bias_seq: power sequencer for the IO-ring n-well bias, pad retention and output enable.
// Defining IO_SEQ_TIMEOUT_EN adds a debounce timeout, a FAULT state and the fault_o port.
module io_nwell_bias_seq #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RAMP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES  = 1024,
    parameter int unsigned CNT_W           = 11
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bias_req_i,
    input  logic vddio_ok_i,
    output logic nw_bias_en_o,
    output logic io_ret_o,
    output logic io_oe_en_o,
`ifdef IO_SEQ_TIMEOUT_EN
    output logic fault_o,
`endif
    output logic ready_o
);
    typedef enum logic [2:0] {
        S_OFF, S_DEBOUNCE, S_RAMP, S_RELEASE, S_ACTIVE, S_SHUTDOWN
`ifdef IO_SEQ_TIMEOUT_EN
        , S_FAULT
`endif
    } state_e;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || RAMP_CYCLES < 1 ||
        CNT_W < $clog2(DEBOUNCE_CYCLES + 1) || CNT_W < $clog2(RAMP_CYCLES + 1) ||
        CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_param_check
        $error("io_nwell_bias_seq: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ok_s, abort;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
`ifdef IO_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]       tmo_q, tmo_d;
`endif

    assign ok_s  = sync_q[SYNC_STAGES-1];
    assign abort = ~bias_req_i | ~ok_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= S_OFF;
            cnt_q   <= '0;
`ifdef IO_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], vddio_ok_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef IO_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Abort conditions are tested before counter expiry so shutdown always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF:      state_d = (bias_req_i && ok_s) ? S_DEBOUNCE : S_OFF;
            S_DEBOUNCE: begin
                if (!bias_req_i)                    state_d = S_OFF;
                else if (ok_s && cnt_q == DEB_LAST) state_d = S_RAMP;
`ifdef IO_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST)         state_d = S_FAULT;
`endif
            end
            S_RAMP:     state_d = abort ? S_SHUTDOWN : (cnt_q == RAMP_LAST) ? S_RELEASE : S_RAMP;
            S_RELEASE:  state_d = abort ? S_SHUTDOWN : S_ACTIVE;
            S_ACTIVE:   state_d = abort ? S_SHUTDOWN : S_ACTIVE;
            S_SHUTDOWN: state_d = (cnt_q == RAMP_LAST) ? S_OFF : S_SHUTDOWN;
`ifdef IO_SEQ_TIMEOUT_EN
            S_FAULT:    state_d = bias_req_i ? S_FAULT : S_OFF;
`endif
            default:    state_d = S_OFF;
        endcase
        cnt_d = (state_d != state_q || (state_q == S_DEBOUNCE && !ok_s)) ? '0 :
                (&cnt_q ? cnt_q : cnt_q + 1'b1);
`ifdef IO_SEQ_TIMEOUT_EN
        tmo_d = (state_q != S_DEBOUNCE) ? '0 : (&tmo_q ? tmo_q : tmo_q + 1'b1);
`endif
    end

    assign nw_bias_en_o = state_q inside {S_RAMP, S_RELEASE, S_ACTIVE, S_SHUTDOWN};
    assign io_ret_o     = !(state_q inside {S_RELEASE, S_ACTIVE});
    assign io_oe_en_o   = state_q == S_ACTIVE;
    assign ready_o      = state_q == S_ACTIVE;
`ifdef IO_SEQ_TIMEOUT_EN
    assign fault_o      = state_q == S_FAULT;
`endif
endmodule

// File: tb/tb_io_nwell_bias_seq.sv
// tb_io_nwell_bias_seq: directed-vector bench for io_nwell_bias_seq (SYNC=2, DEBOUNCE=4, RAMP=8).
module tb_io_nwell_bias_seq;
    logic clk_i = 1'b0, rst_ni = 1'b0, bias_req_i = 1'b0, vddio_ok_i = 1'b0;
    logic nw_bias_en_o, io_ret_o, io_oe_en_o, ready_o;
`ifdef IO_SEQ_TIMEOUT_EN
    logic fault_o;
`endif
    int n_vec = 0, n_err = 0, edge_n = 0;

    // Output vector order: {bias, ret, oe, ready}
    localparam logic [3:0] O_OFF = 4'b0100, O_BIAS = 4'b1100, O_REL = 4'b1000, O_ACT = 4'b1011;

    io_nwell_bias_seq #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RAMP_CYCLES(8), .TIMEOUT_CYCLES(20), .CNT_W(11)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bias_req_i(bias_req_i), .vddio_ok_i(vddio_ok_i),
        .nw_bias_en_o(nw_bias_en_o), .io_ret_o(io_ret_o), .io_oe_en_o(io_oe_en_o),
`ifdef IO_SEQ_TIMEOUT_EN
        .fault_o(fault_o),
`endif
        .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %b, expected %b", tag, edge_n, got, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {nw_bias_en_o, io_ret_o, io_oe_en_o, ready_o};
    endfunction

    task automatic step_to(input int n);
        while (edge_n < n) begin
            @(posedge clk_i);
            edge_n++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; bias_req_i = 1'b0; vddio_ok_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1 edge_n = 0;
    endtask

    // ret=0 requires bias=1; oe=1 requires ret=0
    always @(negedge clk_i)
        if (rst_ni) check("invariant", {2'b00, ~io_ret_o & ~nw_bias_en_o, io_oe_en_o & io_ret_o}, 4'b0000);

    initial begin
        for (int i = 0; i < 6; i++) begin
            bias_req_i = ($urandom() & 1) != 0;
            vddio_ok_i = ($urandom() & 1) != 0;
            @(posedge clk_i);
            #1 check("rst_hold", outs(), O_OFF);
        end
        bias_req_i = 1'b0; vddio_ok_i = 1'b1;
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i);
            #1 check("rst_idle", outs(), O_OFF);
        end

        do_reset();
        bias_req_i = 1'b1; vddio_ok_i = 1'b1;
        step_to(6);  check("pu_pre_bias", outs(), O_OFF);
        step_to(7);  check("pu_bias", outs(), O_BIAS);
        step_to(14); check("pu_ramp_end", outs(), O_BIAS);
        step_to(15); check("pu_release", outs(), O_REL);
        step_to(16); check("pu_active", outs(), O_ACT);
        step_to(29); check("active_hold", outs(), O_ACT);
        bias_req_i = 1'b0;
        step_to(30); check("pd_drop", outs(), O_BIAS);
        step_to(32); bias_req_i = 1'b1;
        step_to(37); check("pd_no_abort", outs(), O_BIAS);
        step_to(38); check("pd_bias_off", outs(), O_OFF);
        step_to(42); check("rereq_debounce", outs(), O_OFF);
        step_to(43); check("rereq_bias", outs(), O_BIAS);
        step_to(45);
        #2 rst_ni = 1'b0;
        #1 check("async_rst", outs(), O_OFF);

        do_reset();
        bias_req_i = 1'b1; vddio_ok_i = 1'b1;
        step_to(4);  vddio_ok_i = 1'b0;
        step_to(5);  vddio_ok_i = 1'b1;
        step_to(7);  check("glitch_hold", outs(), O_OFF);
        step_to(10); check("glitch_pre_bias", outs(), O_OFF);
        step_to(11); check("glitch_bias", outs(), O_BIAS);

        do_reset();
        bias_req_i = 1'b1; vddio_ok_i = 1'b1;
        step_to(7);  check("sl_ramp", outs(), O_BIAS);
        vddio_ok_i = 1'b0;
        step_to(10); check("sl_shutdown", outs(), O_BIAS);
        step_to(15); check("sl_ret15", outs(), O_BIAS);
        step_to(16); check("sl_ret16", outs(), O_BIAS);
        step_to(17); check("sl_pre_off", outs(), O_BIAS);
        step_to(18); check("sl_off", outs(), O_OFF);

        do_reset();
        bias_req_i = 1'b1; vddio_ok_i = 1'b1;
        step_to(4);  bias_req_i = 1'b0;
        step_to(5);  bias_req_i = 1'b1;
        step_to(7);  check("deb_drop", outs(), O_OFF);
        step_to(9);  check("deb_restart", outs(), O_OFF);
        step_to(10); check("deb_bias", outs(), O_BIAS);

        do_reset();
        bias_req_i = 1'b1; vddio_ok_i = 1'b1;
        step_to(15); check("rel_enter", outs(), O_REL);
        bias_req_i = 1'b0;
        step_to(16); check("rel_abort", outs(), O_BIAS);
        step_to(23); check("rel_sd_hold", outs(), O_BIAS);
        step_to(24); check("rel_sd_off", outs(), O_OFF);

`ifdef IO_SEQ_TIMEOUT_EN
        do_reset();
        bias_req_i = 1'b1;
        for (int k = 0; k < 22; k++) begin
            vddio_ok_i = ((k / 3) % 2) == 0;
            step_to(k + 1);
        end
        check("tmo_pre", {3'b000, fault_o}, 4'b0000);
        vddio_ok_i = 1'b0;
        step_to(23);
        check("tmo_fault", {3'b000, fault_o}, 4'b0001);
        check("tmo_outs", outs(), O_OFF);
        step_to(24); check("tmo_hold", {3'b000, fault_o}, 4'b0001);
        bias_req_i = 1'b0;
        step_to(25); check("tmo_clear", {3'b000, fault_o}, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
